trainer_self_test: RTL

Hardware self-test sequencer for the digital trainer gate unit. It drives the gate unit's `a`, `b` and `sel` inputs through every operand/gate combination, samples the gate output `y`, and compares it against an internal truth-table model. It accumulates an error count and captures the first failing vector. It sits beside the gate unit in the user project and reports pass/fail at the end of each run.

---
 rtl/trainer_self_test_if.sv | 22 ++
 rtl/trainer_self_test.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/trainer_self_test_if.sv
// Gate-unit bus between the self-test sequencer (master) and the trainer gate unit (slave).
// The sequencer drives operands and select; the gate unit returns its combinational output.
interface trainer_self_test_if;
  logic       a_out;
  logic       b_out;
  logic [2:0] sel_out;
  logic       y_in;

  modport master (
    output a_out,
    output b_out,
    output sel_out,
    input  y_in
  );

  modport slave (
    input  a_out,
    input  b_out,
    input  sel_out,
    output y_in
  );
endinterface

// File: rtl/trainer_self_test.sv
// Self-test sequencer for the trainer gate unit: walks all 28 {a,b}/sel vectors,
// checks y against a truth-table model, counts errors and captures the first failure.
module trainer_self_test #(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  trainer_self_test_if.master      gate,
  output logic                     busy,
  output logic                     done,
  output logic                     pass,
  output logic [4:0]               err_count,
  output logic                     fail_valid,
  output logic [1:0]               fail_ab,
  output logic [2:0]               fail_sel
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_CHECK  = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  localparam logic [3:0] WAIT_LAST = 4'(SETTLE_CYCLES - 1);
  localparam logic [2:0] SEL_LAST  = 3'd6;
  localparam logic [1:0] AB_LAST   = 2'd3;
  localparam logic [4:0] ERR_MAX   = 5'd31;

  state_t     r_state;
  state_t     w_state_next;

  logic [1:0] r_ab;
  logic [2:0] r_sel;
  logic [3:0] r_wait;
  logic [4:0] r_err;
  logic       r_busy;
  logic       r_done;
  logic       r_pass;
  logic       r_fail_valid;
  logic [1:0] r_fail_ab;
  logic [2:0] r_fail_sel;

  logic       w_load;
  logic       w_check;
  logic       w_last;
  logic       w_expect;
  logic       w_mismatch;
  logic [4:0] w_err_next;

  function automatic logic gate_model(input logic a, input logic b, input logic [2:0] sel);
    logic y;
    case (sel)
      3'd0:    y = a & b;
      3'd1:    y = a | b;
      3'd2:    y = ~(a & b);
      3'd3:    y = ~(a | b);
      3'd4:    y = a ^ b;
      3'd5:    y = ~(a ^ b);
      3'd6:    y = ~a;
      default: y = 1'b0;
    endcase
    return y;
  endfunction

  assign w_last     = (r_ab == AB_LAST) && (r_sel == SEL_LAST);
  assign w_expect   = gate_model(r_ab[1], r_ab[0], r_sel);
  assign w_mismatch = w_check && (gate.y_in != w_expect);
  assign w_err_next = (w_mismatch && (r_err != ERR_MAX)) ? r_err + 5'd1 : r_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // start is only honoured when no run is in progress (IDLE or DONE)
  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_check      = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (start) begin
          w_state_next = S_SETTLE;
          w_load       = 1'b1;
        end
      end
      S_SETTLE: begin
        if (r_wait == WAIT_LAST) begin
          w_state_next = S_CHECK;
        end
      end
      S_CHECK: begin
        w_check      = 1'b1;
        w_state_next = w_last ? S_DONE : S_SETTLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ab         <= '0;
      r_sel        <= '0;
      r_wait       <= '0;
      r_err        <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_pass       <= 1'b0;
      r_fail_valid <= 1'b0;
      r_fail_ab    <= '0;
      r_fail_sel   <= '0;
    end else if (w_load) begin
      r_ab         <= '0;
      r_sel        <= '0;
      r_wait       <= '0;
      r_err        <= '0;
      r_busy       <= 1'b1;
      r_done       <= 1'b0;
      r_pass       <= 1'b0;
      r_fail_valid <= 1'b0;
      r_fail_ab    <= '0;
      r_fail_sel   <= '0;
    end else begin
      if (r_state == S_SETTLE) begin
        r_wait <= (r_wait == WAIT_LAST) ? '0 : r_wait + 4'd1;
      end
      if (w_check) begin
        r_err <= w_err_next;
        if (w_mismatch && !r_fail_valid) begin
          r_fail_valid <= 1'b1;
          r_fail_ab    <= r_ab;
          r_fail_sel   <= r_sel;
        end
        // pass uses the post-check count so the final vector is included
        if (w_last) begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
          r_pass <= (w_err_next == '0);
        end else if (r_sel == SEL_LAST) begin
          r_sel <= '0;
          r_ab  <= r_ab + 2'd1;
        end else begin
          r_sel <= r_sel + 3'd1;
        end
      end
    end
  end

  assign gate.a_out   = r_ab[1];
  assign gate.b_out   = r_ab[0];
  assign gate.sel_out = r_sel;

  assign busy       = r_busy;
  assign done       = r_done;
  assign pass       = r_pass;
  assign err_count  = r_err;
  assign fail_valid = r_fail_valid;
  assign fail_ab    = r_fail_ab;
  assign fail_sel   = r_fail_sel;

endmodule
